// File: rtl/ghost_collision_ctrl.sv
// ghost_collision_ctrl: per-frame Pac-Man/ghost overlap detection plus the
// IDLE/PLAY/FREEZE/OVER game-state machine that drives the ghost movers.
// Optional feature macro: GHOST_COLLISION_LIVES_EN
//   defined     : multi-life play with a FREEZE/respawn interval per lost life
//   not defined : any registered hit ends the game; lives reads as 1,
//                 freeze and respawn stay low
module ghost_collision_ctrl #(
  parameter logic [9:0] HIT_DIST      = 10'd12,
  parameter logic [1:0] LIVES_INIT    = 2'd3,
  parameter logic [7:0] FREEZE_FRAMES = 8'd90,
  parameter logic [7:0] MODE_DIV      = 8'd60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start_game,
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  input  logic [9:0] ghost0_x,
  input  logic [9:0] ghost1_x,
  input  logic [9:0] ghost2_x,
  input  logic [9:0] ghost3_x,
  input  logic [9:0] ghost0_y,
  input  logic [9:0] ghost1_y,
  input  logic [9:0] ghost2_y,
  input  logic [9:0] ghost3_y,
  output logic [4:0] counter,
  output logic       game_over,
  output logic       freeze,
  output logic       respawn,
  output logic       life_lost,
  output logic [1:0] lives,
  output logic [1:0] hit_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_FREEZE = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t     r_state;
  logic [4:0] r_counter;
  logic [7:0] r_div;
  logic       r_game_over;
  logic       r_life_lost;
  logic       r_hit;
  logic [1:0] r_hit_id;
`ifdef GHOST_COLLISION_LIVES_EN
  logic [1:0] r_lives;
  logic [7:0] r_frz_cnt;
  logic       r_freeze;
  logic       r_respawn;
`else
  // Lives and freeze length have no effect in the single-life build.
  logic       w_unused_params;
  assign w_unused_params = ^{LIVES_INIT, FREEZE_FRAMES};
`endif

  logic [9:0] w_gx [4];
  logic [9:0] w_gy [4];
  logic [3:0] w_overlap;
  logic [1:0] w_hit_idx;

  assign w_gx[0] = ghost0_x;
  assign w_gx[1] = ghost1_x;
  assign w_gx[2] = ghost2_x;
  assign w_gx[3] = ghost3_x;
  assign w_gy[0] = ghost0_y;
  assign w_gy[1] = ghost1_y;
  assign w_gy[2] = ghost2_y;
  assign w_gy[3] = ghost3_y;

  // Unsigned distance: always subtract the smaller from the larger, so no wrap.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Per-ghost overlap test, X and Y thresholds applied independently.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives every output and no latch is inferred.
    w_overlap = '0;
    for (int i = 0; i < 4; i++) begin
      w_overlap[i] = (abs_diff(pac_x, w_gx[i]) < HIT_DIST) &&
                     (abs_diff(pac_y, w_gy[i]) < HIT_DIST);
    end
  end

  // Priority encoder: lowest-numbered overlapping ghost wins.
  always_comb begin
    w_hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_overlap[i]) w_hit_idx = 2'(i);
    end
  end

  // Hit register: samples overlaps only while playing, otherwise held clear.
  always_ff @(posedge frame_clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from pre-edge values, independent of statement order.
    if (Reset) begin
      r_hit    <= 1'b0;
      r_hit_id <= 2'd0;
    end else if (r_state == S_PLAY) begin
      r_hit    <= |w_overlap;
      r_hit_id <= w_hit_idx;
    end else begin
      r_hit    <= 1'b0;
      r_hit_id <= 2'd0;
    end
  end

  // Game FSM with registered status outputs and one-frame pulses.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_counter   <= 5'd0;
      r_div       <= 8'd0;
      r_game_over <= 1'b0;
      r_life_lost <= 1'b0;
`ifdef GHOST_COLLISION_LIVES_EN
      r_lives     <= LIVES_INIT;
      r_frz_cnt   <= 8'd0;
      r_freeze    <= 1'b0;
      r_respawn   <= 1'b0;
`endif
    end else begin
      r_life_lost <= 1'b0;
`ifdef GHOST_COLLISION_LIVES_EN
      r_respawn   <= 1'b0;
`endif
      if (r_state == S_IDLE || !start_game) begin
        // Idle values; dropping start_game leaves any active state first,
        // ahead of a pending hit or freeze expiry.
        r_state     <= start_game ? S_PLAY : S_IDLE;
        r_counter   <= 5'd0;
        r_div       <= 8'd0;
        r_game_over <= 1'b0;
`ifdef GHOST_COLLISION_LIVES_EN
        r_lives     <= LIVES_INIT;
        r_frz_cnt   <= 8'd0;
        r_freeze    <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_PLAY: begin
            if (r_div == MODE_DIV - 8'd1) begin
              r_div     <= 8'd0;
              r_counter <= r_counter + 5'd1;
            end else begin
              r_div <= r_div + 8'd1;
            end
            if (r_hit) begin
              r_life_lost <= 1'b1;
`ifdef GHOST_COLLISION_LIVES_EN
              if (r_lives > 2'd1) begin
                r_lives   <= r_lives - 2'd1;
                r_frz_cnt <= 8'd0;
                r_freeze  <= 1'b1;
                r_state   <= S_FREEZE;
              end else begin
                r_lives     <= 2'd0;
                r_game_over <= 1'b1;
                r_state     <= S_OVER;
              end
`else
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
`endif
            end
          end
`ifdef GHOST_COLLISION_LIVES_EN
          S_FREEZE: begin
            if (r_frz_cnt == FREEZE_FRAMES - 8'd1) begin
              r_frz_cnt <= 8'd0;
              r_freeze  <= 1'b0;
              r_respawn <= 1'b1;
              r_state   <= S_PLAY;
            end else begin
              r_frz_cnt <= r_frz_cnt + 8'd1;
            end
          end
`endif
          default: begin
            // OVER: everything holds until start_game drops.
          end
        endcase
      end
    end
  end

  assign counter   = r_counter;
  assign game_over = r_game_over;
  assign life_lost = r_life_lost;
  assign hit_id    = r_hit_id;
`ifdef GHOST_COLLISION_LIVES_EN
  assign lives     = r_lives;
  assign freeze    = r_freeze;
  assign respawn   = r_respawn;
`else
  assign lives     = 2'd1;
  assign freeze    = 1'b0;
  assign respawn   = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Self-checking bench for ghost_collision_ctrl: directed game scenarios and a
// randomized phase, all compared every frame against a frame-level model.
`timescale 1ns/1ps
module tb_ghost_collision_ctrl;

  localparam int HIT  = 12;
  localparam int LINIT = 3;
  localparam int FRZ  = 90;
  localparam int DIV  = 60;
`ifdef GHOST_COLLISION_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       start_game;
  logic [9:0] pac_x, pac_y;
  logic [9:0] gx [4];
  logic [9:0] gy [4];
  logic [4:0] counter;
  logic       game_over, freeze, respawn, life_lost;
  logic [1:0] lives, hit_id;

  ghost_collision_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .start_game(start_game),
    .pac_x     (pac_x),
    .pac_y     (pac_y),
    .ghost0_x  (gx[0]),
    .ghost1_x  (gx[1]),
    .ghost2_x  (gx[2]),
    .ghost3_x  (gx[3]),
    .ghost0_y  (gy[0]),
    .ghost1_y  (gy[1]),
    .ghost2_y  (gy[2]),
    .ghost3_y  (gy[3]),
    .counter   (counter),
    .game_over (game_over),
    .freeze    (freeze),
    .respawn   (respawn),
    .life_lost (life_lost),
    .lives     (lives),
    .hit_id    (hit_id)
  );

  always #5 frame_clk = ~frame_clk;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level model of the game rules.
  typedef enum {M_IDLE, M_PLAY, M_FREEZE, M_OVER} phase_t;
  phase_t m_phase = M_IDLE;
  int     m_lives = LINIT;
  int     m_play_frames = 0;   // PLAY frames since last idle; counter derives from it
  int     m_freeze_left = 0;
  bit     m_pending = 1'b0;    // collision seen on the previous PLAY frame
  int     m_hit_id = 0;
  bit     m_life_lost = 1'b0;
  bit     m_respawn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit touching(input int i);
    int px, py, qx, qy, dx, dy;
    px = pac_x; py = pac_y; qx = gx[i]; qy = gy[i];
    dx = px - qx; if (dx < 0) dx = -dx;
    dy = py - qy; if (dy < 0) dy = -dy;
    return (dx < HIT) && (dy < HIT);
  endfunction

  task automatic model_go_idle();
    m_phase = M_IDLE; m_lives = LINIT; m_play_frames = 0;
  endtask

  task automatic model_step();
    bit any, samp;
    int id;
    any = 1'b0; id = 0;
    for (int i = 3; i >= 0; i--) if (touching(i)) begin any = 1'b1; id = i; end
    m_life_lost = 1'b0; m_respawn = 1'b0;
    if (Reset) begin
      model_go_idle(); m_freeze_left = 0; m_pending = 1'b0; m_hit_id = 0;
      return;
    end
    samp = (m_phase == M_PLAY) && any;
    if (m_phase == M_IDLE) begin
      model_go_idle();
      if (start_game) m_phase = M_PLAY;
    end else if (!start_game) begin
      model_go_idle();
    end else if (m_phase == M_PLAY) begin
      m_play_frames++;
      if (m_pending) begin
        m_life_lost = 1'b1;
        if (LIVES_EN && m_lives > 1) begin
          m_lives--; m_phase = M_FREEZE; m_freeze_left = FRZ;
        end else begin
          m_lives = 0; m_phase = M_OVER;
        end
      end
    end else if (m_phase == M_FREEZE) begin
      m_freeze_left--;
      if (m_freeze_left == 0) begin m_respawn = 1'b1; m_phase = M_PLAY; end
    end
    m_pending = samp;
    m_hit_id  = samp ? id : 0;
  endtask

  // Advance one frame and compare every output with the model.
  task automatic step();
    model_step();
    @(posedge frame_clk); #1;
    check("counter",   counter,   (m_play_frames / DIV) % 32);
    check("game_over", game_over, m_phase == M_OVER);
    check("freeze",    freeze,    m_phase == M_FREEZE);
    check("respawn",   respawn,   m_respawn);
    check("life_lost", life_lost, m_life_lost);
    check("lives",     lives,     LIVES_EN ? m_lives : 1);
    check("hit_id",    hit_id,    m_hit_id);
  endtask

  task automatic place_far();
    for (int i = 0; i < 4; i++) begin gx[i] = 10'(700 + 50 * i); gy[i] = 10'd800; end
  endtask

  // Touch ghost g onto Pac-Man for one frame, then clear; returns after the action edge.
  task automatic one_hit(input int g, input int ox, input int oy);
    pac_x = 10'd100; pac_y = 10'd100;
    place_far(); gx[g] = 10'(100 + ox); gy[g] = 10'(100 + oy);
    step();
    check("hit_id_sampled", hit_id, g);
    check("no_early_life_lost", life_lost, 0);
    place_far();
    step();
    check("life_lost_pulse", life_lost, 1);
  endtask

  // Return to PLAY after a lost life: wait out FREEZE, or restart after OVER.
  task automatic settle();
`ifdef GHOST_COLLISION_LIVES_EN
    repeat (FRZ - 2) step();
    check("freeze_held_90", freeze, 1);
    step();
    check("respawn_pulse", respawn, 1);
    check("freeze_released", freeze, 0);
    step();
    check("respawn_one_frame", respawn, 0);
`else
    start_game = 1'b0; step();
    check("idle_after_over", game_over, 0);
    start_game = 1'b1; step();
`endif
  endtask

  initial begin
    Reset = 1'b1; start_game = 1'b0;
    pac_x = 10'd600; pac_y = 10'd600; place_far();
    step(); step();
    check("rst_counter", counter, 0);
    check("rst_lives", lives, LIVES_EN ? LINIT : 1);
    check("rst_game_over", game_over, 0);
    check("rst_hit_id", hit_id, 0);
    Reset = 1'b0; step();

    // 120 PLAY frames without contact.
    start_game = 1'b1;
    repeat (121) step();
    check("counter_120", counter, 2);
    check("lives_120", lives, LIVES_EN ? 3 : 1);
    check("go_120", game_over, 0);

    // Ghost2 at (110,95): first hit.
    one_hit(2, 10, -5);
    check("lives_hit1", lives, LIVES_EN ? 2 : 1);
    check("freeze_hit1", freeze, LIVES_EN ? 1 : 0);
    step();
    check("life_lost_one_frame", life_lost, 0);
    settle();
    step();  // grace frame

    // Difference exactly HIT_DIST: no hit.
    pac_x = 10'd100; pac_y = 10'd100; place_far(); gx[0] = 10'd112; gy[0] = 10'd100;
    repeat (3) step();
    check("no_hit_at_dist", life_lost, 0);
    check("no_freeze_at_dist", freeze, 0);
    // HIT_DIST-1: hit (second life).
    gx[0] = 10'd111; step(); place_far(); step();
    check("hit_at_dist_m1", life_lost, 1);
    check("lives_hit2", lives, 1);
    step(); settle(); step();

    // Third hit ends the game.
    one_hit(3, -5, 5);
    check("lives_hit3", lives, LIVES_EN ? 0 : 1);
    check("game_over_hit3", game_over, 1);
    repeat (5) step();
    check("over_holds", game_over, 1);
    start_game = 1'b0; step();
    check("idle_lives", lives, LIVES_EN ? 3 : 1);
    check("idle_counter", counter, 0);
    check("idle_game_over", game_over, 0);

    // Counter wrap after 1920 PLAY frames.
    start_game = 1'b1; step();
    repeat (1919) step();
    check("counter_31", counter, 31);
    step();
    check("counter_wrap", counter, 0);

    // Reset in the 40th frame of FREEZE.
    one_hit(1, 0, 0);
    repeat (39) step();
    check("freeze_frame40", freeze, LIVES_EN ? 1 : 0);
    Reset = 1'b1; step();
    check("rst_mid_freeze", freeze, 0);
    check("rst_mid_lives", lives, LIVES_EN ? 3 : 1);
    check("rst_mid_counter", counter, 0);
    check("rst_mid_game_over", game_over, 0);
    Reset = 1'b0;

    // start_game drop on the action frame of a hit.
    step(); step(); step();
    pac_x = 10'd100; pac_y = 10'd100; gx[1] = 10'd100; gy[1] = 10'd100;
    step();
    check("drop_hit_id", hit_id, 1);
    place_far(); start_game = 1'b0; step();
    check("drop_no_life_lost", life_lost, 0);
    check("drop_no_freeze", freeze, 0);
    check("drop_no_over", game_over, 0);
    check("drop_lives", lives, LIVES_EN ? 3 : 1);

    // Randomized play: ghosts wander, sometimes landing near Pac-Man.
    start_game = 1'b1;
    for (int f = 0; f < 1500; f++) begin
      if (f % 16 == 0) begin pac_x = 10'($urandom_range(0, 1023)); pac_y = 10'($urandom_range(0, 1023)); end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          int vx, vy;
          vx = int'(pac_x) + $urandom_range(0, 30) - 15;
          vy = int'(pac_y) + $urandom_range(0, 30) - 15;
          if (vx < 0) vx = 0; if (vx > 1023) vx = 1023;
          if (vy < 0) vy = 0; if (vy > 1023) vy = 1023;
          gx[i] = 10'(vx); gy[i] = 10'(vy);
        end else begin
          gx[i] = 10'($urandom_range(0, 1023)); gy[i] = 10'($urandom_range(0, 1023));
        end
      end
      start_game = ($urandom_range(0, 49) != 0);
      Reset      = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
